queen_row_generator: RTL and testbench

Sequential backtracking solver for the N-queens board that produces placements as one-hot row vectors, column 0 at bit 0 (MSB-first `[0:N-1]` ordering). It sits directly upstream of the one-hot-to-column decoder. It streams each complete solution row by row over a valid/ready handshake, then resumes the search. Solutions are produced in lexicographic order of (row0 column, row1 column, …).

---
 rtl/queen_row_generator.sv | 184 ++++++++++++++++++
 tb/tb_queen_row_generator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_row_generator.sv
// N-queens backtracking solver; streams each solution as one-hot rows (column c at out_row[c]).
// Latency: one candidate per cycle in TRY, one row per cycle in BACKTRACK, N cycles per solution at full rate.
// Backpressure: EMIT holds row/index/last stable while out_valid && !out_ready; the search is paused.
//
// Ports: clk/rst_n (async active-low), start (sampled in IDLE/DONE), out_ready,
//        out_valid/out_row/out_index/out_last (row stream), busy, done, solution_count.
// Optional macro QUEEN_SOLUTION_COUNTER_EN: when defined, solution_count counts solutions
// fully emitted since the last start; otherwise it is tied to zero.
module queen_row_generator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [0:N-1] out_row,
  output logic [2:0]   out_index,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [6:0]   solution_count
);

  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRY,
    S_BACKTRACK,
    S_EMIT,
    S_DONE
  } state_e;

  state_e       state_q;
  logic [0:N-1] board_q [N];
  logic [2:0]   r_q;
  logic [2:0]   c_q;
  logic [2:0]   e_q;

  logic         safe;
  logic [0:7]   attacked;
  logic [0:7]   rowk;
  logic [0:N-1] onehot_c;
  logic [0:N-1] prev_row;
  logic [2:0]   prev_pos;

  // Columns attacked by rows above r: each placed queen covers its own column
  // and both diagonals, shifted by the row distance. Rows are padded to 8 bits
  // so diagonal shifts never lose bits that a smaller board would need.
  always_comb begin
    attacked = '0;
    rowk     = '0;
    for (int k = 0; k < N; k++) begin
      rowk      = '0;
      rowk[0:N-1] = board_q[k];
      if (k < int'(r_q)) begin
        attacked = attacked | rowk | (rowk >> (int'(r_q) - k)) | (rowk << (int'(r_q) - k));
      end
    end
    safe = !attacked[c_q];
  end

  // One-hot of candidate column, and the queen position in row r-1.
  always_comb begin
    onehot_c = '0;
    prev_row = '0;
    prev_pos = '0;
    for (int i = 0; i < N; i++) begin
      onehot_c[i] = (3'(i) == c_q);
      if (3'(i) == r_q - 3'd1) prev_row = board_q[i];
    end
    for (int i = 0; i < N; i++) begin
      if (prev_row[i]) prev_pos = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int k = 0; k < N; k++) board_q[k] <= '0;
      r_q <= '0;
      c_q <= '0;
      e_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int k = 0; k < N; k++) board_q[k] <= '0;
            r_q     <= '0;
            c_q     <= '0;
            state_q <= S_TRY;
          end
        end
        S_TRY: begin
          if (safe) begin
            for (int k = 0; k < N; k++) begin
              if (3'(k) == r_q) board_q[k] <= onehot_c;
            end
            if (r_q == LAST) begin
              e_q     <= '0;
              state_q <= S_EMIT;
            end else begin
              r_q <= r_q + 3'd1;
              c_q <= '0;
            end
          end else if (c_q == LAST) begin
            state_q <= S_BACKTRACK;
          end else begin
            c_q <= c_q + 3'd1;
          end
        end
        S_BACKTRACK: begin
          if (r_q == 3'd0) begin
            state_q <= S_DONE;
          end else begin
            for (int k = 0; k < N; k++) begin
              if (3'(k) == r_q || 3'(k) == r_q - 3'd1) board_q[k] <= '0;
            end
            r_q <= r_q - 3'd1;
            // Row r-1 exhausted: keep unwinding; otherwise resume at its next column.
            if (prev_pos != LAST) begin
              c_q     <= prev_pos + 3'd1;
              state_q <= S_TRY;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (e_q == LAST) begin
              // Row N-1 has exactly one legal column, so resume from row N-1's parent.
              e_q     <= '0;
              r_q     <= LAST;
              state_q <= S_BACKTRACK;
            end else begin
              e_q <= e_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef QUEEN_SOLUTION_COUNTER_EN
  logic [6:0] sol_cnt_q;
  logic       start_go;
  logic       emit_done;

  assign start_go  = (state_q == S_IDLE || state_q == S_DONE) && start;
  assign emit_done = (state_q == S_EMIT) && out_ready && (e_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sol_cnt_q <= '0;
    end else if (start_go) begin
      sol_cnt_q <= '0;
    end else if (emit_done) begin
      sol_cnt_q <= sol_cnt_q + 7'd1;
    end
  end

  assign solution_count = sol_cnt_q;
`else
  assign solution_count = 7'd0;
`endif

  // Outputs decode registered state only; out_ready never reaches an output.
  always_comb begin
    out_row = '0;
    if (state_q == S_EMIT) begin
      for (int k = 0; k < N; k++) begin
        if (3'(k) == e_q) out_row = board_q[k];
      end
    end
  end

  assign out_valid = (state_q == S_EMIT);
  assign out_index = e_q;
  assign out_last  = (state_q == S_EMIT) && (e_q == LAST);
  assign busy      = (state_q == S_TRY) || (state_q == S_BACKTRACK) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_queen_row_generator.sv
// Self-checking bench for queen_row_generator at N=8 and N=4.
// Reference solutions come from brute-force enumeration of permutations in lexicographic order.
// Checks reset state, solution stream, stalls, start while busy, mid-emit reset and done hold.
module tb_queen_row_generator;

  logic clk;
  logic rst_n;

  logic       start8, rdy8, vld8, last8, busy8, done8;
  logic [0:7] row8;
  logic [2:0] idx8;
  logic [6:0] cnt8;

  logic       start4, rdy4, vld4, last4, busy4, done4;
  logic [0:3] row4;
  logic [2:0] idx4;
  logic [6:0] cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] model_q [$];
  logic [23:0] sol8 [$];
  logic [23:0] sol4 [$];

  queen_row_generator #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .out_ready(rdy8),
    .out_valid(vld8), .out_row(row8), .out_index(idx8), .out_last(last8),
    .busy(busy8), .done(done8), .solution_count(cnt8)
  );

  queen_row_generator #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .out_ready(rdy4),
    .out_valid(vld4), .out_row(row4), .out_index(idx4), .out_last(last4),
    .busy(busy4), .done(done4), .solution_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All N-queens solutions in lexicographic order, column of row i at bits [3i+:3].
  task automatic gen_sols(input int n);
    int perm [8];
    int i, j, t;
    bit ok, more;
    logic [23:0] s;
    model_q.delete();
    for (int k = 0; k < 8; k++) perm[k] = k;
    more = 1'b1;
    while (more) begin
      ok = 1'b1;
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++)
          if (perm[a] - perm[b] == b - a || perm[b] - perm[a] == b - a) ok = 1'b0;
      if (ok) begin
        s = '0;
        for (int a = 0; a < n; a++) s[3*a +: 3] = 3'(perm[a]);
        model_q.push_back(s);
      end
      i = n - 2;
      while (i >= 0 && perm[i] >= perm[i+1]) i--;
      if (i < 0) begin
        more = 1'b0;
      end else begin
        j = n - 1;
        while (perm[j] <= perm[i]) j--;
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        for (int a = i + 1, b = n - 1; a < b; a++, b--) begin
          t = perm[a]; perm[a] = perm[b]; perm[b] = t;
        end
      end
    end
  endtask

  task automatic run8(input bit rnd, input bit poke, input int max_sols);
    int si, ei, cyc;
    bit stalled;
    logic [0:7] prow, erow;
    logic [2:0] pidx, col;
    logic plast;
    logic [23:0] s;
    si = 0; ei = 0; cyc = 0; stalled = 1'b0;
    prow = '0; pidx = '0; plast = 1'b0;
    @(negedge clk); start8 = 1'b1; rdy8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    check("busy_after_start", {31'b0, busy8}, 1);
    check("done_low_after_start", {31'b0, done8}, 0);
    while (!done8 && si < max_sols && cyc < 30000) begin
      if (stalled) begin
        check("stall_row", {24'b0, row8}, {24'b0, prow});
        check("stall_index", {29'b0, idx8}, {29'b0, pidx});
        check("stall_last", {31'b0, last8}, {31'b0, plast});
      end
`ifdef QUEEN_SOLUTION_COUNTER_EN
      check("count_progress", {25'b0, cnt8}, si);
`else
      check("count_tied_zero", {25'b0, cnt8}, 0);
`endif
      rdy8   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start8 = poke && busy8 && ($urandom_range(0, 7) == 0);
      if (!vld8) begin
        check("row_zero_when_invalid", {24'b0, row8}, 0);
        stalled = 1'b0;
      end else if (!rdy8) begin
        stalled = 1'b1;
        prow = row8; pidx = idx8; plast = last8;
      end else begin
        stalled = 1'b0;
        s = (si < sol8.size()) ? sol8[si] : '0;
        col = s[3*ei +: 3];
        erow = '0;
        erow[col] = 1'b1;
        check("row", {24'b0, row8}, {24'b0, erow});
        check("index", {29'b0, idx8}, ei);
        check("last", {31'b0, last8}, {31'b0, ei == 7});
        ei++;
        if (ei == 8) begin
          ei = 0;
          si++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    if (max_sols >= 1000) begin
      check("search_done", {31'b0, done8}, 1);
      check("solutions_emitted", si, sol8.size());
`ifdef QUEEN_SOLUTION_COUNTER_EN
      check("final_count", {25'b0, cnt8}, sol8.size());
`else
      check("final_count_zero", {25'b0, cnt8}, 0);
`endif
      repeat (5) @(negedge clk);
      check("done_holds", {31'b0, done8}, 1);
      check("idle_not_busy", {31'b0, busy8}, 0);
      check("idle_not_valid", {31'b0, vld8}, 0);
    end else begin
      check("partial_solutions", si, max_sols);
    end
    rdy8 = 1'b1;
  endtask

  initial begin
    int si, ei, cyc;
    logic [23:0] s;
    logic [2:0] col;
    logic [0:3] erow4;

    gen_sols(8); sol8 = model_q;
    gen_sols(4); sol4 = model_q;

    rst_n = 1'b0;
    start8 = 1'b0; rdy8 = 1'b0;
    start4 = 1'b0; rdy4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, vld8}, 0);
    check("rst_row", {24'b0, row8}, 0);
    check("rst_index", {29'b0, idx8}, 0);
    check("rst_last", {31'b0, last8}, 0);
    check("rst_busy", {31'b0, busy8}, 0);
    check("rst_done", {31'b0, done8}, 0);
    check("rst_count", {25'b0, cnt8}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_busy", {31'b0, busy8}, 0);

    // Full search at full rate, then with random backpressure and start pokes.
    run8(1'b0, 1'b0, 1000);
    run8(1'b1, 1'b1, 1000);

    // Reset while the third row of the first solution is presented.
    @(negedge clk); start8 = 1'b1; rdy8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    cyc = 0;
    while (!(vld8 && idx8 == 3'd2) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_third_row", {29'b0, idx8}, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, vld8}, 0);
    check("midrst_row", {24'b0, row8}, 0);
    check("midrst_index", {29'b0, idx8}, 0);
    check("midrst_last", {31'b0, last8}, 0);
    check("midrst_busy", {31'b0, busy8}, 0);
    check("midrst_done", {31'b0, done8}, 0);
    check("midrst_count", {25'b0, cnt8}, 0);
    @(negedge clk); rst_n = 1'b1;
    run8(1'b0, 1'b0, 1);

    // N=4 board.
    @(negedge clk); start4 = 1'b1; rdy4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    si = 0; ei = 0; cyc = 0;
    while (!done4 && cyc < 2000) begin
      if (vld4) begin
        s = (si < sol4.size()) ? sol4[si] : '0;
        col = s[3*ei +: 3];
        erow4 = '0;
        erow4[col[1:0]] = 1'b1;
        check("n4_row", {28'b0, row4}, {28'b0, erow4});
        check("n4_index", {29'b0, idx4}, ei);
        check("n4_last", {31'b0, last4}, {31'b0, ei == 3});
        ei++;
        if (ei == 4) begin
          ei = 0;
          si++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("n4_done", {31'b0, done4}, 1);
    check("n4_solutions", si, sol4.size());
`ifdef QUEEN_SOLUTION_COUNTER_EN
    check("n4_count", {25'b0, cnt4}, sol4.size());
`else
    check("n4_count_zero", {25'b0, cnt4}, 0);
`endif
    repeat (10) @(negedge clk);
    check("n4_done_holds", {31'b0, done4}, 1);
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    check("n4_restart_done_clear", {31'b0, done4}, 0);
    check("n4_restart_busy", {31'b0, busy4}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
